regfile_wb_queue: RTL and testbench

Write-back queue directly upstream of the 32x32 2R1W register file.
- Accepts write requests from execution units through a valid/ready handshake and buffers them in a small FIFO.
- Drains one entry per cycle onto the register file write port (WR, RW, Data_IN, EN).
- Provides forwarding lookups and a pending-register vector, so the decode stage can read the newest value or stall on registers that have not yet been committed.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/wb_fifo.sv | 76 +++++++
 rtl/regfile_wb_queue.sv | 117 +++++++++++
 tb/tb_regfile_wb_queue.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the 32x32 2R1W register file and its write-back queue.
// Provides the data/address widths and the write-request payload struct.
package regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  // One pending register-file write: destination register and data.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Storage FIFO for the write-back queue.
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   push, push_entry - write one entry at the tail (caller guarantees not full)
//   pop            - retire the head entry (caller guarantees not empty)
//   head           - oldest entry
//   count          - occupancy
//   age_entry/age_valid - entries ordered newest (index 0) to oldest, with valids
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  output wb_entry_t              age_entry [DEPTH],
  output logic [DEPTH-1:0]       age_valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t          mem [DEPTH];
  logic [DEPTH-1:0]   vld;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;

  // Pointers, occupancy and per-entry valids; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld    <= '0;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + PTR_W'(1);
        vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        vld[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by vld.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

  // Live entries are contiguous just behind wr_ptr, so walk back from it.
  always_comb begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      age_entry[k] = mem[wr_ptr - PTR_W'(k + 1)];
      age_valid[k] = vld[wr_ptr - PTR_W'(k + 1)];
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register file write port.
// Buffers execution-unit writes, drains one per cycle onto WR/RW/Data_IN,
// and offers forwarding lookups plus a pending-register vector to decode.
// Ports:
//   Clock, Reset           - clock, async active-low reset
//   in_valid/in_ready/in_addr/in_data - write request handshake
//   rf_stall               - register file cannot take a write this cycle
//   WR, RW, Data_IN, EN    - registered register-file write port
//   chk_addr1/2 -> chk_hit1/2, chk_data1/2 - combinational forwarding lookups
//   pending                - one bit per register with an uncommitted write
//   count                  - FIFO occupancy
module regfile_wb_queue #(
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   rf_stall,
  output logic                   WR,
  output logic [ADDR_W-1:0]      RW,
  output logic [DATA_W-1:0]      Data_IN,
  output logic                   EN,
  input  logic [ADDR_W-1:0]      chk_addr1,
  input  logic [ADDR_W-1:0]      chk_addr2,
  output logic                   chk_hit1,
  output logic                   chk_hit2,
  output logic [DATA_W-1:0]      chk_data1,
  output logic [DATA_W-1:0]      chk_data2,
  output logic [(2**ADDR_W)-1:0] pending,
  output logic [$clog2(DEPTH):0] count
);

  import regfile_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t        in_entry;
  wb_entry_t        head;
  wb_entry_t        age_entry [DEPTH];
  logic [DEPTH-1:0] age_valid;
  logic             push;
  logic             pop;

  assign in_entry = '{addr: in_addr, data: in_data};
  assign in_ready = (count != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && !rf_stall;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (Clock),
    .rst_n      (Reset),
    .push       (push),
    .push_entry (in_entry),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .age_entry  (age_entry),
    .age_valid  (age_valid)
  );

  // Register-file write port; RW/Data_IN hold when no pop occurs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      WR      <= 1'b0;
      RW      <= '0;
      Data_IN <= '0;
      EN      <= 1'b0;
    end else begin
      EN <= 1'b1;
      WR <= pop;
      if (pop) begin
        RW      <= head.addr;
        Data_IN <= head.data;
      end
    end
  end

  // Forwarding and pending: scan oldest (output register) to newest so the
  // youngest matching entry is the one left standing.
  always_comb begin
    chk_hit1  = 1'b0;
    chk_hit2  = 1'b0;
    chk_data1 = '0;
    chk_data2 = '0;
    pending   = '0;
    if (WR) begin
      pending[RW] = 1'b1;
      if (RW == chk_addr1) begin
        chk_hit1  = 1'b1;
        chk_data1 = Data_IN;
      end
      if (RW == chk_addr2) begin
        chk_hit2  = 1'b1;
        chk_data2 = Data_IN;
      end
    end
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (age_valid[k]) begin
        pending[age_entry[k].addr] = 1'b1;
        if (age_entry[k].addr == chk_addr1) begin
          chk_hit1  = 1'b1;
          chk_data1 = age_entry[k].data;
        end
        if (age_entry[k].addr == chk_addr2) begin
          chk_hit2  = 1'b1;
          chk_data2 = age_entry[k].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue with a scoreboard of expected writes.
module tb_regfile_wb_queue;
  import regfile_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        rf_stall;
  logic        WR;
  logic [4:0]  RW;
  logic [31:0] Data_IN;
  logic        EN;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        chk_hit1;
  logic        chk_hit2;
  logic [31:0] chk_data1;
  logic [31:0] chk_data2;
  logic [31:0] pending;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;
  wb_entry_t sb [$];

  regfile_wb_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .rf_stall  (rf_stall),
    .WR        (WR),
    .RW        (RW),
    .Data_IN   (Data_IN),
    .EN        (EN),
    .chk_addr1 (chk_addr1),
    .chk_addr2 (chk_addr2),
    .chk_hit1  (chk_hit1),
    .chk_hit2  (chk_hit2),
    .chk_data1 (chk_data1),
    .chk_data2 (chk_data2),
    .pending   (pending),
    .count     (count)
  );

  always #5 Clock = ~Clock;

  // Every issued write must match the oldest accepted request.
  always @(negedge Clock) begin
    if (Reset === 1'b1 && WR === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL wr_unexpected: got RW=%0d Data_IN=%h, expected no write", RW, Data_IN);
      end else begin
        wb_entry_t exp;
        exp = sb.pop_front();
        if (RW !== exp.addr || Data_IN !== exp.data) begin
          fails++;
          $display("FAIL wr_order: got RW=%0d Data_IN=%h, expected RW=%0d Data_IN=%h",
                   RW, Data_IN, exp.addr, exp.data);
        end
      end
    end
  end

  // Drive one cycle of request inputs; record it if it will be accepted.
  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    if (v && in_ready === 1'b1) sb.push_back('{addr: a, data: d});
    @(negedge Clock);
  endtask

  task automatic test_reset;
    Reset = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    rf_stall = 1'b0; chk_addr1 = '0; chk_addr2 = '0;
    repeat (5) begin
      @(negedge Clock);
      tests++;
      if ({WR, EN, RW, Data_IN, pending, count, chk_hit1, chk_hit2} !== '0) begin
        fails++;
        $display("FAIL reset_zero: got WR=%b EN=%b RW=%0d Data_IN=%h pending=%h count=%0d hit=%b%b, expected all 0",
                 WR, EN, RW, Data_IN, pending, count, chk_hit1, chk_hit2);
      end
    end
    Reset = 1'b1;
    @(negedge Clock);
    tests++;
    if (EN !== 1'b1 || in_ready !== 1'b1 || count !== 3'd0 || WR !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got EN=%b in_ready=%b count=%0d WR=%b, expected 1 1 0 0",
               EN, in_ready, count, WR);
    end
  endtask

  task automatic test_back_to_back;
    rf_stall = 1'b0; chk_addr1 = 5'd0; chk_addr2 = 5'd1;
    drive(1'b1, 5'd0, 32'hABCDEFAB);
    tests++;
    if (WR !== 1'b0 || pending !== 32'h1 || chk_hit1 !== 1'b1 || chk_data1 !== 32'hABCDEFAB) begin
      fails++;
      $display("FAIL b2b_queued: got WR=%b pending=%h hit1=%b data1=%h, expected 0 00000001 1 abcdefab",
               WR, pending, chk_hit1, chk_data1);
    end
    drive(1'b1, 5'd1, 32'h01234567);
    tests++;
    if (WR !== 1'b1 || RW !== 5'd0 || Data_IN !== 32'hABCDEFAB || pending !== 32'h3) begin
      fails++;
      $display("FAIL b2b_first: got WR=%b RW=%0d Data_IN=%h pending=%h, expected 1 0 abcdefab 00000003",
               WR, RW, Data_IN, pending);
    end
    drive(1'b0, 5'd0, 32'h0);
    tests++;
    if (WR !== 1'b1 || RW !== 5'd1 || Data_IN !== 32'h01234567 || pending !== 32'h2) begin
      fails++;
      $display("FAIL b2b_second: got WR=%b RW=%0d Data_IN=%h pending=%h, expected 1 1 01234567 00000002",
               WR, RW, Data_IN, pending);
    end
    drive(1'b0, 5'd0, 32'h0);
    tests++;
    if (WR !== 1'b0 || pending !== 32'h0 || Data_IN !== 32'h01234567) begin
      fails++;
      $display("FAIL b2b_idle: got WR=%b pending=%h Data_IN=%h, expected 0 00000000 01234567 (held)",
               WR, pending, Data_IN);
    end
  endtask

  task automatic test_stall;
    rf_stall = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, 5'(2 + i), 32'h1000_0000 + 32'(i));
    tests++;
    if (in_ready !== 1'b0 || count !== 3'd4 || pending !== 32'h3C || WR !== 1'b0) begin
      fails++;
      $display("FAIL stall_full: got in_ready=%b count=%0d pending=%h WR=%b, expected 0 4 0000003c 0",
               in_ready, count, pending, WR);
    end
    rf_stall = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drive(1'b0, 5'd0, 32'h0);
      tests++;
      if (WR !== 1'b1 || RW !== 5'(2 + j)) begin
        fails++;
        $display("FAIL stall_drain%0d: got WR=%b RW=%0d, expected 1 %0d", j, WR, RW, 2 + j);
      end
    end
    drive(1'b0, 5'd0, 32'h0);
    tests++;
    if (WR !== 1'b0 || count !== 3'd0) begin
      fails++;
      $display("FAIL stall_empty: got WR=%b count=%0d, expected 0 0", WR, count);
    end
  endtask

  task automatic test_forward;
    rf_stall = 1'b1; chk_addr1 = 5'd7; chk_addr2 = 5'd8;
    drive(1'b1, 5'd7, 32'h11);
    tests++;
    if (chk_hit1 !== 1'b1 || chk_data1 !== 32'h11) begin
      fails++;
      $display("FAIL fwd_one: got hit1=%b data1=%h, expected 1 00000011", chk_hit1, chk_data1);
    end
    drive(1'b1, 5'd7, 32'h22);
    tests++;
    if (chk_hit1 !== 1'b1 || chk_data1 !== 32'h22 || chk_hit2 !== 1'b0 || chk_data2 !== 32'h0) begin
      fails++;
      $display("FAIL fwd_newest: got hit1=%b data1=%h hit2=%b data2=%h, expected 1 00000022 0 00000000",
               chk_hit1, chk_data1, chk_hit2, chk_data2);
    end
    rf_stall = 1'b0;
    drive(1'b0, 5'd0, 32'h0);
    tests++;
    if (WR !== 1'b1 || chk_hit1 !== 1'b1 || chk_data1 !== 32'h22) begin
      fails++;
      $display("FAIL fwd_fifo_over_out: got WR=%b hit1=%b data1=%h, expected 1 1 00000022",
               WR, chk_hit1, chk_data1);
    end
    drive(1'b0, 5'd0, 32'h0);
    tests++;
    if (chk_hit1 !== 1'b1 || chk_data1 !== 32'h22 || count !== 3'd0) begin
      fails++;
      $display("FAIL fwd_out_reg: got hit1=%b data1=%h count=%0d, expected 1 00000022 0",
               chk_hit1, chk_data1, count);
    end
    drive(1'b0, 5'd0, 32'h0);
    tests++;
    if (chk_hit1 !== 1'b0 || chk_data1 !== 32'h0) begin
      fails++;
      $display("FAIL fwd_clear: got hit1=%b data1=%h, expected 0 00000000", chk_hit1, chk_data1);
    end
  endtask

  task automatic test_full_pop;
    int budget;
    rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 5'(8 + i), 32'hF0 + 32'(i));
    tests++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_fill: got count=%0d in_ready=%b, expected 4 0", count, in_ready);
    end
    rf_stall = 1'b0;
    drive(1'b1, 5'd12, 32'hC0);
    tests++;
    if (count !== 3'd3 || in_ready !== 1'b1 || WR !== 1'b1 || RW !== 5'd8) begin
      fails++;
      $display("FAIL full_pop_only: got count=%0d in_ready=%b WR=%b RW=%0d, expected 3 1 1 8",
               count, in_ready, WR, RW);
    end
    drive(1'b1, 5'd12, 32'hC0);
    tests++;
    if (count !== 3'd3 || RW !== 5'd9) begin
      fails++;
      $display("FAIL full_push_pop: got count=%0d RW=%0d, expected 3 9", count, RW);
    end
    budget = 0;
    drive(1'b0, 5'd0, 32'h0);
    while ((count !== 3'd0 || WR !== 1'b0) && budget < 20) begin
      drive(1'b0, 5'd0, 32'h0);
      budget++;
    end
    tests++;
    if (budget >= 20) begin
      fails++;
      $display("FAIL full_drain_timeout: got count=%0d WR=%b after 20 cycles, expected 0 0", count, WR);
    end
  endtask

  task automatic test_reset_mid_drain;
    rf_stall = 1'b1; chk_addr1 = 5'd14;
    for (int i = 0; i < 3; i++) drive(1'b1, 5'(13 + i), 32'hD0 + 32'(i));
    rf_stall = 1'b0;
    drive(1'b0, 5'd0, 32'h0);
    #2;
    Reset = 1'b0;
    #1;
    sb.delete();
    tests++;
    if (WR !== 1'b0 || count !== 3'd0 || pending !== 32'h0 || chk_hit1 !== 1'b0 || EN !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: got WR=%b count=%0d pending=%h hit1=%b EN=%b, expected 0 0 00000000 0 0",
               WR, count, pending, chk_hit1, EN);
    end
    @(negedge Clock);
    Reset = 1'b1;
    repeat (6) drive(1'b0, 5'd0, 32'h0);
    tests++;
    if (WR !== 1'b0 || count !== 3'd0 || EN !== 1'b1) begin
      fails++;
      $display("FAIL rst_after: got WR=%b count=%0d EN=%b, expected 0 0 1", WR, count, EN);
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_stall;
    test_forward;
    test_full_pop;
    test_reset_mid_drain;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d unissued writes, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
